// File: rtl/mld_pkg.sv
// Shared constants and types for the serial (7,4) cyclic encoder.
package mld_pkg;

  localparam int N     = 7;
  localparam int K     = 4;
  localparam int PAR_W = N - K;
  localparam int CNT_W = 2;

  // {g2,g1,g0} of the monic degree-3 generator: x^3 + x + 1
  localparam logic [PAR_W-1:0] G_LOW_DEFAULT = 3'b011;

  typedef enum logic {MSG, PAR} enc_state_t;

  // Count value at which the current phase ends.
  function automatic logic [CNT_W-1:0] last_cnt(input enc_state_t s);
    return (s == MSG) ? CNT_W'(K - 1) : CNT_W'(PAR_W - 1);
  endfunction

  // Codeword bit index (6..0) of the bit being loaded in phase s at count c.
  function automatic logic [2:0] cw_idx(input enc_state_t s, input logic [CNT_W-1:0] c);
    return (s == MSG) ? 3'(N - 1) - {1'b0, c} : 3'(PAR_W - 1) - {1'b0, c};
  endfunction

endpackage

// File: rtl/lfsr_div_3_bit.sv
// Three-stage division LFSR: load_en divides by x^3+{g2,g1,g0}, shift_en
// shifts the remainder out of r[2] with zero fill.
module lfsr_div_3_bit
  import mld_pkg::*;
#(
  parameter logic [PAR_W-1:0] G_LOW = G_LOW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic             din,
  output logic [PAR_W-1:0] r
);

  logic fb;

  assign fb = din ^ r[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r <= '0;
    end else if (load_en) begin
      r <= {r[1] ^ (fb & G_LOW[2]), r[0] ^ (fb & G_LOW[1]), fb & G_LOW[0]};
    end else if (shift_en) begin
      r <= {r[1:0], 1'b0};
    end
  end

endmodule

// File: rtl/cyclic_encoder_7_4_serial.sv
// Serial systematic (7,4) cyclic encoder: 4 message bits in, c6..c0 out.
// CYC_ENC_ERR_INJECT_EN adds inj_mask to flip chosen output bits.
module cyclic_encoder_7_4_serial
  import mld_pkg::*;
#(
  parameter logic [PAR_W-1:0] G_LOW = G_LOW_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_bit,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_bit,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef CYC_ENC_ERR_INJECT_EN
  input  logic [N-1:0] inj_mask,
`endif
  output logic         out_last
);

  enc_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             out_bit_nxt, out_valid_nxt, out_last_nxt;
  logic             slot_free, in_xfer, load_en, shift_en, bit_flip;
  logic [PAR_W-1:0] r;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == MSG) && slot_free;
  assign in_xfer   = in_valid && in_ready;
  assign load_en   = in_xfer;
  assign shift_en  = (state == PAR) && slot_free;

  lfsr_div_3_bit #(.G_LOW(G_LOW)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load_en  (load_en),
    .shift_en (shift_en),
    .din      (in_bit),
    .r        (r)
  );

`ifdef CYC_ENC_ERR_INJECT_EN
  // The first message bit uses the live mask; the rest use the captured copy.
  logic [N-1:0] mask_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
    end else if (in_xfer && cnt == '0) begin
      mask_q <= inj_mask;
    end
  end

  always_comb begin
    bit_flip = mask_q[cw_idx(state, cnt)];
    if (state == MSG && cnt == '0) bit_flip = inj_mask[N-1];
  end
`else
  assign bit_flip = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    out_bit_nxt   = out_bit;
    out_valid_nxt = out_valid;
    out_last_nxt  = out_last;
    if (slot_free) begin
      out_valid_nxt = 1'b0;
      out_last_nxt  = 1'b0;
    end
    unique case (state)
      MSG: begin
        if (in_xfer) begin
          out_bit_nxt   = in_bit ^ bit_flip;
          out_valid_nxt = 1'b1;
          out_last_nxt  = 1'b0;
          if (cnt == last_cnt(MSG)) begin
            cnt_nxt   = '0;
            state_nxt = PAR;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      PAR: begin
        if (slot_free) begin
          out_bit_nxt   = r[2] ^ bit_flip;
          out_valid_nxt = 1'b1;
          if (cnt == last_cnt(PAR)) begin
            out_last_nxt = 1'b1;
            cnt_nxt      = '0;
            state_nxt    = MSG;
          end else begin
            out_last_nxt = 1'b0;
            cnt_nxt      = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = MSG;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= MSG;
      cnt       <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_bit   <= out_bit_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
    end
  end

endmodule
